// File: rtl/sort_mem_slave.sv
// Word-addressed memory target for the sort engine's AR/R + AW/W/B bus.
// One read and one write in flight at a time, programmable response latency, backdoor preload/peek.
module sort_mem_slave #(
  parameter int ADDR_WDTH = 4,
  parameter int DATA_WDTH = 32,
  parameter int RESP_WDTH = 1,
  parameter int MEM_DEPTH = 16,
  parameter int READ_LAT  = 0,
  parameter int WRITE_LAT = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ar_valid,
  output logic                 ar_ready,
  input  logic [ADDR_WDTH-1:0] ar_address,
  output logic                 r_valid,
  input  logic                 r_ready,
  output logic [DATA_WDTH-1:0] r_data,
  output logic [RESP_WDTH-1:0] r_resp,
  input  logic                 aw_valid,
  output logic                 aw_ready,
  input  logic [ADDR_WDTH-1:0] aw_address,
  input  logic                 w_valid,
  output logic                 w_ready,
  input  logic [DATA_WDTH-1:0] w_data,
  output logic                 b_valid,
  input  logic                 b_ready,
  output logic [RESP_WDTH-1:0] b_resp,
  input  logic                 init_we,
  input  logic [ADDR_WDTH-1:0] init_addr,
  input  logic [DATA_WDTH-1:0] init_data,
  output logic [DATA_WDTH-1:0] peek_data,
  output logic [15:0]          wr_count
);

  localparam logic [RESP_WDTH-1:0] RESP_OKAY   = '0;
  localparam logic [RESP_WDTH-1:0] RESP_SLVERR = RESP_WDTH'(1);
  localparam logic [3:0]           RD_LAST     = 4'(READ_LAT - 1);
  localparam logic [3:0]           WR_LAST     = 4'(WRITE_LAT - 1);

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_e;
  typedef enum logic [1:0] {W_COLLECT, W_WAIT, W_RESP} w_state_e;

  logic [DATA_WDTH-1:0] mem_q [MEM_DEPTH];

  r_state_e             r_state_q, r_state_d;
  logic [ADDR_WDTH-1:0] r_addr_q, r_addr_d;
  logic [3:0]           r_cnt_q, r_cnt_d;
  logic                 r_valid_q, r_valid_d;
  logic [DATA_WDTH-1:0] r_data_q, r_data_d;
  logic [RESP_WDTH-1:0] r_resp_q, r_resp_d;

  w_state_e             w_state_q, w_state_d;
  logic                 aw_held_q, aw_held_d;
  logic                 w_held_q, w_held_d;
  logic [ADDR_WDTH-1:0] aw_addr_q, aw_addr_d;
  logic [DATA_WDTH-1:0] w_data_q, w_data_d;
  logic [3:0]           w_cnt_q, w_cnt_d;
  logic                 b_valid_q, b_valid_d;
  logic [RESP_WDTH-1:0] b_resp_q, b_resp_d;
  logic [15:0]          wr_count_q, wr_count_d;
  logic                 wr_commit;

  function automatic logic in_range(input logic [ADDR_WDTH-1:0] a);
    return int'(a) < MEM_DEPTH;
  endfunction

  // Read channel: the R_RESP cycle with r_valid_q low is the single mem sampling cycle.
  always_comb begin
    r_state_d = r_state_q;
    r_addr_d  = r_addr_q;
    r_cnt_d   = r_cnt_q;
    r_valid_d = r_valid_q;
    r_data_d  = r_data_q;
    r_resp_d  = r_resp_q;
    case (r_state_q)
      R_IDLE: begin
        if (ar_valid) begin
          r_addr_d = ar_address;
          r_cnt_d  = '0;
          if (READ_LAT == 0) r_state_d = R_RESP;
          else               r_state_d = R_WAIT;
        end
      end
      R_WAIT: begin
        if (r_cnt_q == RD_LAST) r_state_d = R_RESP;
        else                    r_cnt_d   = r_cnt_q + 4'd1;
      end
      R_RESP: begin
        if (!r_valid_q) begin
          r_valid_d = 1'b1;
          r_data_d  = in_range(r_addr_q) ? mem_q[r_addr_q] : '0;
          r_resp_d  = in_range(r_addr_q) ? RESP_OKAY : RESP_SLVERR;
        end else if (r_ready) begin
          r_valid_d = 1'b0;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      r_cnt_q   <= '0;
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
      r_resp_q  <= RESP_OKAY;
    end else begin
      r_state_q <= r_state_d;
      r_cnt_q   <= r_cnt_d;
      r_valid_q <= r_valid_d;
      r_data_q  <= r_data_d;
      r_resp_q  <= r_resp_d;
    end
    r_addr_q <= r_addr_d;
  end

  // Write channel: AW and W latch independently; the commit happens on entry to the response.
  always_comb begin
    w_state_d  = w_state_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    aw_addr_d  = aw_addr_q;
    w_data_d   = w_data_q;
    w_cnt_d    = w_cnt_q;
    b_valid_d  = b_valid_q;
    b_resp_d   = b_resp_q;
    wr_count_d = wr_count_q;
    wr_commit  = 1'b0;
    case (w_state_q)
      W_COLLECT: begin
        if (!aw_held_q && aw_valid) begin
          aw_held_d = 1'b1;
          aw_addr_d = aw_address;
        end
        if (!w_held_q && w_valid) begin
          w_held_d = 1'b1;
          w_data_d = w_data;
        end
        if ((aw_held_q || aw_valid) && (w_held_q || w_valid)) begin
          w_cnt_d = '0;
          if (WRITE_LAT == 0) w_state_d = W_RESP;
          else                w_state_d = W_WAIT;
        end
      end
      W_WAIT: begin
        if (w_cnt_q == WR_LAST) w_state_d = W_RESP;
        else                    w_cnt_d   = w_cnt_q + 4'd1;
      end
      W_RESP: begin
        if (!b_valid_q) begin
          wr_commit  = 1'b1;
          b_valid_d  = 1'b1;
          b_resp_d   = in_range(aw_addr_q) ? RESP_OKAY : RESP_SLVERR;
          wr_count_d = wr_count_q + 16'd1;
        end else if (b_ready) begin
          b_valid_d = 1'b0;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          w_state_d = W_COLLECT;
        end
      end
      default: w_state_d = W_COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q  <= W_COLLECT;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      w_cnt_q    <= '0;
      b_valid_q  <= 1'b0;
      b_resp_q   <= RESP_OKAY;
      wr_count_q <= '0;
    end else begin
      w_state_q  <= w_state_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      w_cnt_q    <= w_cnt_d;
      b_valid_q  <= b_valid_d;
      b_resp_q   <= b_resp_d;
      wr_count_q <= wr_count_d;
    end
    aw_addr_q <= aw_addr_d;
    w_data_q  <= w_data_d;
  end

  // The bus write is placed last so it overrides a same-address backdoor write on the same edge.
  always_ff @(posedge clk) begin
    if (init_we && in_range(init_addr)) mem_q[init_addr] <= init_data;
    if (wr_commit && !rst && in_range(aw_addr_q)) mem_q[aw_addr_q] <= w_data_q;
  end

  assign ar_ready  = !rst && (r_state_q == R_IDLE);
  assign r_valid   = !rst && r_valid_q;
  assign r_data    = r_data_q;
  assign r_resp    = r_resp_q;
  assign aw_ready  = !rst && (w_state_q == W_COLLECT) && !aw_held_q;
  assign w_ready   = !rst && (w_state_q == W_COLLECT) && !w_held_q;
  assign b_valid   = !rst && b_valid_q;
  assign b_resp    = b_resp_q;
  assign wr_count  = wr_count_q;
  assign peek_data = in_range(init_addr) ? mem_q[init_addr] : '0;

endmodule
